// File: rtl/btn_debounce_multi.sv
// Per-channel button conditioner: 2-FF sync, stability-window debounce, press/release/long-press pulses.
// Pin change reaches btn_out after STABLE_CYC+3 edges; pulses coincide with that edge; no backpressure.
module btn_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int STABLE_CYC = 16,
    parameter int LONG_CYC   = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] rel_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] long_hold
);

    localparam int CW = $clog2(STABLE_CYC);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYC - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        logic          r_cand;
        logic [CW-1:0] r_cnt;
        logic          r_out;
        logic          r_press;
        logic          r_rel;
        logic          r_long;
        logic          r_lhold;
        logic [HW-1:0] r_hold;
        logic          w_upd;
        logic          w_out_nxt;
        logic          w_rise;
        logic          w_fall;
        logic          w_long_fire;

        always_comb begin
            w_upd       = (r_s2 == r_cand) && (r_cnt == CNT_MAX) && (r_cand != r_out);
            w_out_nxt   = w_upd ? r_cand : r_out;
            w_rise      = w_out_nxt & ~r_out;
            w_fall      = ~w_out_nxt & r_out;
            // A release landing on the firing edge must swallow the long pulse.
            w_long_fire = r_out & w_out_nxt & (r_hold == HOLD_FIRE);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= btn_in[i];
                r_s2 <= r_s1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cand <= 1'b0;
                r_cnt  <= '0;
            end else if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out   <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
                r_lhold <= 1'b0;
                r_hold  <= '0;
            end else begin
                r_out   <= w_out_nxt;
                r_press <= w_rise;
                r_rel   <= w_fall;
                r_long  <= w_long_fire;
                if (w_fall) begin
                    r_lhold <= 1'b0;
                end else if (w_long_fire) begin
                    r_lhold <= 1'b1;
                end
                // Saturates at LONG_CYC so the long pulse fires only once per press.
                if (w_rise || w_fall) begin
                    r_hold <= '0;
                end else if (r_out && (r_hold != HOLD_MAX)) begin
                    r_hold <= r_hold + HW'(1);
                end
            end
        end

        assign btn_out[i]     = r_out;
        assign press_pulse[i] = r_press;
        assign rel_pulse[i]   = r_rel;
        assign long_pulse[i]  = r_long;
        assign long_hold[i]   = r_lhold;
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi (2 channels, STABLE_CYC=4, LONG_CYC=10) against a sliding-window reference model.
module tb_btn_debounce_multi;
    localparam int NCH  = 2;
    localparam int S    = 4;
    localparam int L    = 10;
    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_in;
    logic [1:0] btn_out, press_pulse, rel_pulse, long_pulse, long_hold;
    logic [9:0] dut_v;

    btn_debounce_multi #(.N_CH(NCH), .STABLE_CYC(S), .LONG_CYC(L)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_out(btn_out),
        .press_pulse(press_pulse), .rel_pulse(rel_pulse),
        .long_pulse(long_pulse), .long_hold(long_hold)
    );

    assign dut_v = {btn_out, press_pulse, rel_pulse, long_pulse, long_hold};

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: pin samples per edge since reset release, plus derived output state.
    int         k;
    logic [1:0] hist [0:HMAX-1];
    logic [1:0] m_out, m_press, m_rel, m_long, m_hold;
    int         m_pedge [2];

    function automatic logic pin(int ch, int j);
        if (j < 1 || j > k) return 1'b0;
        return hist[j][ch];
    endfunction

    // Level v is accepted once S+1 consecutive synchronised samples all show it.
    function automatic bit win_all(int ch, int t, logic v);
        for (int j = t - S - 2; j <= t - 2; j++)
            if (pin(ch, j) !== v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [9:0] exp_v();
        return {m_out, m_press, m_rel, m_long, m_hold};
    endfunction

    task automatic model_reset();
        k = 0;
        hist[0] = 2'b00;
        m_out = '0; m_press = '0; m_rel = '0; m_long = '0; m_hold = '0;
        m_pedge[0] = -100000;
        m_pedge[1] = -100000;
    endtask

    task automatic model_step();
        for (int ch = 0; ch < NCH; ch++) begin
            logic prev, nv;
            prev = m_out[ch];
            nv   = prev;
            if (win_all(ch, k, 1'b1))      nv = 1'b1;
            else if (win_all(ch, k, 1'b0)) nv = 1'b0;
            m_press[ch] = nv & ~prev;
            m_rel[ch]   = prev & ~nv;
            if (m_press[ch]) m_pedge[ch] = k;
            m_long[ch] = nv && ((k - m_pedge[ch]) == L);
            if (!nv)              m_hold[ch] = 1'b0;
            else if (m_long[ch])  m_hold[ch] = 1'b1;
            m_out[ch] = nv;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        if (k >= HMAX) begin
            $display("FAIL history_overflow k=%0d limit=%0d", k, HMAX);
            $fatal(1);
        end
        hist[k] = btn_in;
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 2'b11;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            if (dut_v !== 10'b0) begin n_fail++; $display("FAIL reset_hold got=%b want=%b", dut_v, 10'b0); end
            n_vec++;
        end
        #4 rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL reset_model k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (c == 6) begin
                if (btn_out !== 2'b00) begin n_fail++; $display("FAIL reset_early btn_out=%b want=00", btn_out); end
                n_vec++;
            end
            if (c == 7) begin
                if (btn_out !== 2'b11 || press_pulse !== 2'b11) begin
                    n_fail++; $display("FAIL reset_press btn_out=%b press=%b want=11/11", btn_out, press_pulse);
                end
                n_vec++;
            end
        end
        btn_in = 2'b00;
        repeat (10) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL reset_release k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
        end
    endtask

    task automatic test_bounce();
        int d, presses, rels, rise_k;
        presses = 0; rels = 0; rise_k = -1;
        for (int i = 0; i < 10; i++) begin
            btn_in[0] = (i % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                tick();
                if (dut_v !== exp_v()) begin n_fail++; $display("FAIL bounce_toggle k=%0d got=%b want=%b", k, dut_v, exp_v()); end
                n_vec++;
                if (press_pulse[0]) presses++;
                if (rel_pulse[0]) rels++;
            end
        end
        btn_in[0] = 1'b1;
        d = k;
        repeat (12) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL bounce_settle k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (press_pulse[0]) begin presses++; rise_k = k; end
            if (rel_pulse[0]) rels++;
        end
        if (rise_k !== d + 7) begin n_fail++; $display("FAIL bounce_latency rise_at=%0d want=%0d", rise_k, d + 7); end
        n_vec++;
        if (presses !== 1 || rels !== 0) begin n_fail++; $display("FAIL bounce_pulses press=%0d rel=%0d want 1/0", presses, rels); end
        n_vec++;
        btn_in[0] = 1'b0;
        repeat (10) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL bounce_release k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        btn_in[1] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) btn_in[1] = 1'b0;
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL glitch_model k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (btn_out[1] || press_pulse[1] || rel_pulse[1]) seen++;
        end
        if (seen !== 0) begin n_fail++; $display("FAIL glitch_leak active_cycles=%0d want=0", seen); end
        n_vec++;
    endtask

    task automatic test_long_press();
        int d, press_k, long_k, rel_k, nlong, hold_bad;
        press_k = -1; long_k = -1; rel_k = -1; nlong = 0; hold_bad = 0;
        btn_in[0] = 1'b1;
        d = k;
        for (int c = 0; c < 42; c++) begin
            if (c == 30) btn_in[0] = 1'b0;
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL long_model k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (press_pulse[0]) press_k = k;
            if (long_pulse[0]) begin long_k = k; nlong++; end
            if (rel_pulse[0]) rel_k = k;
            if (long_k >= 0 && rel_k < 0 && long_hold[0] !== 1'b1) hold_bad++;
            if (rel_k >= 0 && long_hold[0] !== 1'b0) hold_bad++;
        end
        if (press_k !== d + 7) begin n_fail++; $display("FAIL long_press_at got=%0d want=%0d", press_k, d + 7); end
        n_vec++;
        if (long_k - press_k !== L || nlong !== 1) begin
            n_fail++; $display("FAIL long_timing gap=%0d count=%0d want %0d/1", long_k - press_k, nlong, L);
        end
        n_vec++;
        if (rel_k !== d + 37 || hold_bad !== 0) begin
            n_fail++; $display("FAIL long_hold_level rel_at=%0d bad=%0d want %0d/0", rel_k, hold_bad, d + 37);
        end
        n_vec++;
    endtask

    task automatic test_release_boundary();
        int press_k, rel_k, nlong, nrel, hold_seen, long_at_rel;
        press_k = -1; rel_k = -1; nlong = 0; nrel = 0; hold_seen = 0; long_at_rel = -1;
        btn_in[0] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c == 10) btn_in[0] = 1'b0;
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL bound_model k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (press_pulse[0]) press_k = k;
            if (rel_pulse[0]) begin rel_k = k; nrel++; long_at_rel = long_pulse[0]; end
            if (long_pulse[0]) nlong++;
            if (long_hold[0]) hold_seen++;
        end
        if (rel_k - press_k !== L || nrel !== 1) begin
            n_fail++; $display("FAIL bound_release gap=%0d rels=%0d want %0d/1", rel_k - press_k, nrel, L);
        end
        n_vec++;
        if (nlong !== 0 || hold_seen !== 0 || long_at_rel !== 0) begin
            n_fail++; $display("FAIL bound_suppress long=%0d hold=%0d long_at_rel=%0d want 0/0/0", nlong, hold_seen, long_at_rel);
        end
        n_vec++;
    endtask

    task automatic test_mid_reset();
        btn_in = 2'b01;
        for (int c = 0; c < 25; c++) begin
            if (c == 20) btn_in = 2'b11;
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL midrst_pre k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
        end
        #2 rst_n = 1'b0;
        #1;
        if (dut_v !== 10'b0) begin n_fail++; $display("FAIL midrst_async got=%b want=%b", dut_v, 10'b0); end
        n_vec++;
        repeat (2) begin
            @(posedge clk); #1;
            if (dut_v !== 10'b0) begin n_fail++; $display("FAIL midrst_hold got=%b want=%b", dut_v, 10'b0); end
            n_vec++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL midrst_model k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
            if (c < 7 && (press_pulse !== 2'b00 || rel_pulse !== 2'b00)) begin
                n_fail++; $display("FAIL midrst_nopulse k=%0d press=%b rel=%b want 00/00", k, press_pulse, rel_pulse);
            end
            if (c < 7) n_vec++;
            if (c == 7) begin
                if (press_pulse !== 2'b11) begin n_fail++; $display("FAIL midrst_repress press=%b want=11", press_pulse); end
                n_vec++;
            end
        end
        btn_in = 2'b00;
        repeat (12) begin
            tick();
            if (dut_v !== exp_v()) begin n_fail++; $display("FAIL midrst_release k=%0d got=%b want=%b", k, dut_v, exp_v()); end
            n_vec++;
        end
    endtask

    task automatic test_random();
        int dur;
        for (int n = 0; n < 60; n++) begin
            btn_in = 2'($urandom_range(0, 3));
            dur = $urandom_range(1, 14);
            repeat (dur) begin
                tick();
                if (dut_v !== exp_v()) begin n_fail++; $display("FAIL random k=%0d got=%b want=%b", k, dut_v, exp_v()); end
                n_vec++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_long_press();
        test_release_boundary();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
